// File: rtl/endec_frame_assembler_pkg.sv
// Shared constants for the endec frame assembler.
// Holds mode codes, default widths, byte targets and FSM state codes.
package endec_frame_assembler_pkg;

    localparam logic ENCODE_MODE = 1'b0;
    localparam logic DECODE_MODE = 1'b1;

    localparam int DEF_BYTE_W      = 8;
    localparam int DEF_ENC_FRAME_W = 128;
    localparam int DEF_DEC_FRAME_W = 384;

    localparam int ENC_BYTES = 16;
    localparam int DEC_BYTES = 48;

    localparam int CNT_W = 6;

    localparam logic S_FILL = 1'b0;
    localparam logic S_HOLD = 1'b1;

endpackage

// File: rtl/endec_frame_assembler.sv
// Byte-stream to parallel frame assembler feeding endec_interface.
// Ports: sys_clk/rst(async low)/en; i_byte/i_byte_valid/o_byte_ready stream;
// i_mode_sel latched at byte 0; i_abort clears; i_frame_ack releases a held
// frame; o_*_data_frame, o_mode_sel, o_frame_valid, o_byte_cnt.
module endec_frame_assembler
    import endec_frame_assembler_pkg::*;
#(
    parameter int BYTE_W      = DEF_BYTE_W,
    parameter int ENC_FRAME_W = DEF_ENC_FRAME_W,
    parameter int DEC_FRAME_W = DEF_DEC_FRAME_W
) (
    input  logic                   sys_clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   i_mode_sel,
    input  logic [BYTE_W-1:0]      i_byte,
    input  logic                   i_byte_valid,
    output logic                   o_byte_ready,
    input  logic                   i_abort,
    input  logic                   i_frame_ack,
    output logic [ENC_FRAME_W-1:0] o_encoder_data_frame,
    output logic [DEC_FRAME_W-1:0] o_decoder_data_frame,
    output logic                   o_mode_sel,
    output logic                   o_frame_valid,
    output logic [CNT_W-1:0]       o_byte_cnt
);

    localparam logic [CNT_W-1:0] ENC_TGT = CNT_W'(ENC_FRAME_W / BYTE_W);
    localparam logic [CNT_W-1:0] DEC_TGT = CNT_W'(DEC_FRAME_W / BYTE_W);

    logic                   r_state;
    logic [DEC_FRAME_W-1:0] r_frame;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_mode;

    logic                   w_accept;
    logic                   w_mode_eff;
    logic [CNT_W-1:0]       w_target;
    logic [CNT_W-1:0]       w_cnt_nxt;

    // Ready is gated by rst so the stream is stalled during reset assertion.
    assign o_byte_ready = rst & en & (r_state == S_FILL);
    assign w_accept     = i_byte_valid & o_byte_ready;

    // The first byte of a frame decides its length, so look at the live
    // mode input on that byte rather than the stale latch.
    assign w_mode_eff = (r_cnt == '0) ? i_mode_sel : r_mode;
    assign w_target   = (w_mode_eff == DECODE_MODE) ? DEC_TGT : ENC_TGT;
    assign w_cnt_nxt  = r_cnt + 1'b1;

    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_FILL;
            r_frame <= '0;
            r_cnt   <= '0;
            r_mode  <= ENCODE_MODE;
        end else if (en) begin
            if (i_abort) begin
                r_state <= S_FILL;
                r_frame <= '0;
                r_cnt   <= '0;
            end else if (r_state == S_HOLD) begin
                if (i_frame_ack) begin
                    r_state <= S_FILL;
                    r_frame <= '0;
                    r_cnt   <= '0;
                end
            end else if (w_accept) begin
                r_frame <= {r_frame[DEC_FRAME_W-BYTE_W-1:0], i_byte};
                r_cnt   <= w_cnt_nxt;
                if (r_cnt == '0) begin
                    r_mode <= i_mode_sel;
                end
                if (w_cnt_nxt == w_target) begin
                    r_state <= S_HOLD;
                end
            end
        end
    end

    assign o_encoder_data_frame = r_frame[ENC_FRAME_W-1:0];
    assign o_decoder_data_frame = r_frame;
    assign o_mode_sel           = r_mode;
    assign o_frame_valid        = (r_state == S_HOLD);
    assign o_byte_cnt           = r_cnt;

endmodule

// File: tb/tb_endec_frame_assembler.sv
// Scoreboard bench for endec_frame_assembler with a byte-list frame model.
module tb_endec_frame_assembler;

    logic         clk;
    logic         rst;
    logic         en;
    logic         mode_sel;
    logic [7:0]   byte_in;
    logic         byte_valid;
    logic         byte_ready;
    logic         abort;
    logic         ack;
    logic [127:0] enc_frame;
    logic [383:0] dec_frame;
    logic         mode_out;
    logic         frame_valid;
    logic [5:0]   byte_cnt;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [383:0] frame;
        logic         mode;
    } exp_t;

    exp_t         sb_q[$];
    logic [383:0] last_exp;
    logic         prev_valid;

    endec_frame_assembler dut (
        .sys_clk              (clk),
        .rst                  (rst),
        .en                   (en),
        .i_mode_sel           (mode_sel),
        .i_byte               (byte_in),
        .i_byte_valid         (byte_valid),
        .o_byte_ready         (byte_ready),
        .i_abort              (abort),
        .i_frame_ack          (ack),
        .o_encoder_data_frame (enc_frame),
        .o_decoder_data_frame (dec_frame),
        .o_mode_sel           (mode_out),
        .o_frame_valid        (frame_valid),
        .o_byte_cnt           (byte_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [383:0] act,
                       input logic [383:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
        end
    endtask

    // Monitor: every rising edge of o_frame_valid must match the oldest
    // frame the stimulus promised.
    initial prev_valid = 1'b0;
    always @(negedge clk) begin
        if (rst && frame_valid && !prev_valid) begin
            if (sb_q.size() == 0) begin
                chk("sb_unexpected_frame", 1, 0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("sb_dec_frame", dec_frame, e.frame);
                chk("sb_enc_frame", {256'd0, enc_frame},
                    {256'd0, e.frame[127:0]});
                chk("sb_mode", {383'd0, mode_out}, {383'd0, e.mode});
            end
        end
        prev_valid = rst & frame_valid;
    end

    task automatic send_byte(input logic [7:0] b, input logic m);
        int k;
        @(negedge clk);
        byte_valid = 1'b1;
        byte_in    = b;
        mode_sel   = m;
        k = 0;
        while (!byte_ready && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (!byte_ready) begin
            chk("ready_timeout", 0, 1);
        end
        @(posedge clk);
    endtask

    task automatic idle();
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    // Frame model: byte i of an n-byte frame lands at byte position n-1-i,
    // all bits above the frame are zero.
    task automatic run_frame(input logic m0, input bit sw, input int sw_after,
                             input bit gaps, input bit rnd, input int base);
        int n;
        logic [7:0] bytes[$];
        exp_t e;
        n = (m0 == 1'b1) ? 48 : 16;
        e.frame = '0;
        e.mode  = m0;
        for (int i = 0; i < n; i++) begin
            bytes.push_back(rnd ? 8'($urandom) : 8'(base + i));
        end
        for (int i = 0; i < n; i++) begin
            e.frame[8*(n-1-i) +: 8] = bytes[i];
        end
        sb_q.push_back(e);
        last_exp = e.frame;
        for (int i = 0; i < n; i++) begin
            send_byte(bytes[i], (sw && i >= sw_after) ? ~m0 : m0);
            if (i != n - 1 && (gaps || (rnd && $urandom_range(0, 3) == 0)))
                idle();
        end
        idle();
        chk("valid_after_last", {383'd0, frame_valid}, 384'd1);
        chk("ready_in_hold", {383'd0, byte_ready}, 384'd0);
        chk("cnt_at_target", {378'd0, byte_cnt}, 384'(n));
    endtask

    task automatic do_ack();
        @(negedge clk);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        chk("ack_valid", {383'd0, frame_valid}, 384'd0);
        chk("ack_cnt", {378'd0, byte_cnt}, 384'd0);
        chk("ack_frame", dec_frame, 384'd0);
    endtask

    initial begin
        rst        = 1'b0;
        en         = 1'b1;
        mode_sel   = 1'b0;
        byte_in    = 8'd0;
        byte_valid = 1'b0;
        abort      = 1'b0;
        ack        = 1'b0;
        last_exp   = '0;

        repeat (2) @(negedge clk);
        chk("rst_ready", {383'd0, byte_ready}, 384'd0);
        chk("rst_valid", {383'd0, frame_valid}, 384'd0);
        chk("rst_cnt", {378'd0, byte_cnt}, 384'd0);
        chk("rst_mode", {383'd0, mode_out}, 384'd0);
        chk("rst_frame", dec_frame, 384'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", {383'd0, byte_ready}, 384'd1);

        // Encode frame 0x00..0x0F back to back.
        run_frame(1'b0, 0, 0, 0, 0, 0);
        chk("enc_literal", {256'd0, enc_frame},
            {256'd0, 128'h000102030405060708090A0B0C0D0E0F});
        chk("enc_upper_zero", {128'd0, dec_frame[383:128]}, 384'd0);
        do_ack();

        // Decode frame 0x01..0x30 with a gap after every byte.
        run_frame(1'b1, 0, 0, 1, 0, 1);
        chk("dec_msb", {376'd0, dec_frame[383:376]}, 384'h01);
        chk("dec_lsb", {376'd0, dec_frame[7:0]}, 384'h30);
        do_ack();

        // Mode switch mid-frame is ignored.
        run_frame(1'b0, 1, 3, 0, 0, 8'h40);

        // Hold stability for 20 cycles.
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("hold_frame", dec_frame, last_exp);
            chk("hold_valid", {383'd0, frame_valid}, 384'd1);
        end

        // Ack with a byte in the same cycle: byte taken one cycle later.
        @(negedge clk);
        ack        = 1'b1;
        byte_valid = 1'b1;
        byte_in    = 8'hAA;
        mode_sel   = 1'b0;
        chk("ack_cycle_ready", {383'd0, byte_ready}, 384'd0);
        @(negedge clk);
        ack = 1'b0;
        chk("ack_byte_not_taken", {378'd0, byte_cnt}, 384'd0);
        chk("ack_valid_low", {383'd0, frame_valid}, 384'd0);
        @(negedge clk);
        chk("aa_taken_cnt", {378'd0, byte_cnt}, 384'd1);
        chk("aa_taken_frame", dec_frame, 384'hAA);
        byte_valid = 1'b0;

        // Abort after 7 bytes, with a byte in the same cycle.
        for (int i = 0; i < 6; i++) send_byte(8'(8'h10 + i), 1'b0);
        @(negedge clk);
        chk("pre_abort_cnt", {378'd0, byte_cnt}, 384'd7);
        abort      = 1'b1;
        byte_valid = 1'b1;
        byte_in    = 8'h55;
        @(negedge clk);
        abort      = 1'b0;
        byte_valid = 1'b0;
        chk("abort_cnt", {378'd0, byte_cnt}, 384'd0);
        chk("abort_frame", dec_frame, 384'd0);
        chk("abort_valid", {383'd0, frame_valid}, 384'd0);
        run_frame(1'b0, 0, 0, 0, 1, 0);
        do_ack();

        // Randomized frames in both modes.
        for (int f = 0; f < 6; f++) begin
            run_frame(1'($urandom), 0, 0, 0, 1, 0);
            repeat ($urandom_range(0, 4)) @(negedge clk);
            do_ack();
        end

        // en=0 freeze, ack in fill ignored, async reset mid-fill.
        for (int i = 0; i < 10; i++) send_byte(8'(i), 1'b1);
        @(negedge clk);
        en         = 1'b0;
        byte_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("en0_ready", {383'd0, byte_ready}, 384'd0);
            chk("en0_cnt", {378'd0, byte_cnt}, 384'd10);
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("en0_abort_ignored", {378'd0, byte_cnt}, 384'd10);
        byte_valid = 1'b0;
        en         = 1'b1;
        ack        = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        chk("fill_ack_ignored", {378'd0, byte_cnt}, 384'd10);
        chk("fill_mode", {383'd0, mode_out}, 384'd1);
        #2 rst = 1'b0;
        #1;
        chk("async_rst_cnt", {378'd0, byte_cnt}, 384'd0);
        chk("async_rst_frame", dec_frame, 384'd0);
        chk("async_rst_mode", {383'd0, mode_out}, 384'd0);
        chk("async_rst_ready", {383'd0, byte_ready}, 384'd0);
        chk("async_rst_valid", {383'd0, frame_valid}, 384'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        chk("sb_drained", 384'(sb_q.size()), 384'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
